bcd_seg_display: RTL and testbench

//  Sequential binary-to-7-segment display driver, generalising the fixed 0..21 two-digit

---
 rtl/bcd_seg_display.sv | 143 ++++++++++++++
 tb/tb_bcd_seg_display.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seg_display.sv
// Sequential binary-to-7-segment driver: double-dabble conversion, one input bit per clock,
// then a registered update of all digit patterns with leading-zero blanking and overflow dashes.
module bcd_seg_display #(
  parameter int IN_WIDTH      = 8,
  parameter int NUM_DIGITS    = 3,
  parameter int BLANK_LEADING = 1,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [IN_WIDTH-1:0]     value,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CMP_W = IN_WIDTH + BCD_W;
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  localparam logic [6:0] PAT_DASH  = 7'b0111111;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_ZERO  = 7'b1000000;

  // 10**NUM_DIGITS always fits in 4*NUM_DIGITS bits, so CMP_W is wide enough for the compare.
  function automatic logic [CMP_W-1:0] pow10(input int n);
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < n; i++) p = p * CMP_W'(10);
    return p;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] p);
    return (ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0011000;
      default: p = PAT_BLANK;
    endcase
    return p;
  endfunction

  function automatic logic [7*NUM_DIGITS-1:0] reset_seg();
    logic [7*NUM_DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      r[7*k +: 7] = polarity((k == 0 || BLANK_LEADING == 0) ? PAT_ZERO : PAT_BLANK);
    return r;
  endfunction

  localparam logic [CMP_W-1:0]        LIMIT     = pow10(NUM_DIGITS);
  localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = reset_seg();

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                  state_reg;
  logic [IN_WIDTH-1:0]     bin_reg;
  logic [BCD_W-1:0]        bcd_reg;
  logic [BCD_W-1:0]        bcd_adj;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    ovf_next_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    ovf_reg;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [7*NUM_DIGITS-1:0] seg_next;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [3:0] nib;
      logic       lead_zero;
      assign nib = bcd_reg[4*gi +: 4];
      assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      // Blank when this digit and every more significant digit are zero; digit 0 always shows.
      assign lead_zero = (gi > 0) && (BLANK_LEADING != 0) && (bcd_reg[BCD_W-1:4*gi] == '0);
      assign seg_next[7*gi +: 7] = polarity(ovf_next_reg ? PAT_DASH :
                                            lead_zero    ? PAT_BLANK : enc_digit(nib));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      ovf_next_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      seg_reg      <= SEG_RESET;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load) begin
            bin_reg      <= value;
            bcd_reg      <= '0;
            cnt_reg      <= CNT_W'(IN_WIDTH - 1);
            ovf_next_reg <= ({{BCD_W{1'b0}}, value} >= LIMIT);
            busy_reg     <= 1'b1;
            state_reg    <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the adjusted BCD falls off; the overflow flag already covers that case.
          bcd_reg <= BCD_W'({bcd_adj, bin_reg[IN_WIDTH-1]});
          bin_reg <= bin_reg << 1;
          if (cnt_reg == '0) state_reg <= UPDATE;
          else               cnt_reg   <= cnt_reg - 1'b1;
        end
        UPDATE: begin
          seg_reg   <= seg_next;
          ovf_reg   <= ovf_next_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = ovf_reg;
  assign seg      = seg_reg;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench: three parameterisations driven in lockstep, checked against an
// arithmetic digit model; a negedge monitor pops expectations whenever done pulses.
module tb_bcd_seg_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [7:0] value = 8'd0;

  logic        busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [20:0] seg0;
  logic [13:0] seg1;
  logic [20:0] seg2;

  bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy0), .done(done0), .overflow(ovf0), .seg(seg0));
  bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(2), .BLANK_LEADING(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy1), .done(done1), .overflow(ovf1), .seg(seg1));
  bcd_seg_display #(.IN_WIDTH(8), .NUM_DIGITS(3), .BLANK_LEADING(0), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .reset(reset), .load(load), .value(value),
    .busy(busy2), .done(done2), .overflow(ovf2), .seg(seg2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int ND [3] = '{3, 2, 3};
  localparam int BL [3] = '{1, 1, 0};
  localparam int AL [3] = '{1, 1, 0};

  logic [2:0][20:0] seg_a;
  logic [2:0]       done_a, busy_a, ovf_a;
  assign seg_a  = {seg2, {7'b0, seg1}, seg0};
  assign done_a = {done2, done1, done0};
  assign busy_a = {busy2, busy1, busy0};
  assign ovf_a  = {ovf2, ovf1, ovf0};

  typedef struct packed {
    logic [2:0][20:0] seg;
    logic [2:0]       ovf;
    logic [31:0]      cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  logic [2:0][20:0] shown_seg;
  logic [2:0]       shown_ovf;
  bit               mon_en = 1'b0;
  int               n_tests = 0;
  int               n_fail = 0;

  // Reference: digits from decimal arithmetic, blanking from magnitude comparison.
  function automatic logic [20:0] model_seg(int v, int nd, int bl, int al);
    logic [6:0]  lut [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    logic [20:0] s = '0;
    logic [6:0]  pat;
    int          lim = 1;
    int          pk = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    for (int k = 0; k < nd; k++) begin
      if (v >= lim)                    pat = 7'b0111111;
      else if (bl != 0 && k > 0 && v < pk) pat = 7'b1111111;
      else                             pat = lut[(v / pk) % 10];
      if (al == 0) pat = ~pat;
      s[7*k +: 7] = pat;
      pk = pk * 10;
    end
    return s;
  endfunction

  function automatic logic model_ovf(int v, int nd);
    int lim = 1;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    return v >= lim;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int v, int c0);
    exp_t e;
    e.cyc = 32'(c0 + 9);
    for (int i = 0; i < 3; i++) begin
      e.seg[i] = model_seg(v, ND[i], BL[i], AL[i]);
      e.ovf[i] = model_ovf(v, ND[i]);
    end
    sb.push_back(e);
  endtask

  task automatic set_shown_reset();
    for (int i = 0; i < 3; i++) shown_seg[i] = model_seg(0, ND[i], BL[i], AL[i]);
    shown_ovf = 3'b000;
  endtask

  // Monitor: on done compare against the scoreboard head, otherwise seg/overflow must hold.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done_a != 3'b000) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=%b want no pulse (cyc %0d)", done_a, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          for (int i = 0; i < 3; i++) begin
            check($sformatf("done%0d", i), 64'(done_a[i]), 64'd1);
            check($sformatf("busy_at_done%0d", i), 64'(busy_a[i]), 64'd0);
            check($sformatf("seg%0d", i), 64'(seg_a[i]), 64'(mon_e.seg[i]));
            check($sformatf("ovf%0d", i), 64'(ovf_a[i]), 64'(mon_e.ovf[i]));
          end
          shown_seg = mon_e.seg;
          shown_ovf = mon_e.ovf;
          $display("[TB] cyc=%0d done seg0=%b seg1=%b seg2=%b ovf=%b",
                   cyc, seg0, seg1, seg2, ovf_a);
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("hold_seg%0d", i), 64'(seg_a[i]), 64'(shown_seg[i]));
          check($sformatf("hold_ovf%0d", i), 64'(ovf_a[i]), 64'(shown_ovf[i]));
        end
      end
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_a[0]) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done within 40 cycles want done (cyc %0d)", cyc);
      sb.delete();
    end
  endtask

  // One conversion; optionally pulse load with 99 while busy (must be ignored).
  task automatic convert(int v, bit busy_pulse);
    int c0;
    @(posedge clk); #1;
    value = 8'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    c0    = cyc;
    load  = 1'b0;
    value = 8'($urandom_range(0, 255));
    push(v, c0);
    @(negedge clk);
    check("busy_after_load", 64'(busy_a), 64'(3'b111));
    if (busy_pulse) begin
      @(posedge clk);
      @(posedge clk); #1;
      value = 8'd99;
      load  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      load  = 1'b0;
      value = 8'($urandom_range(0, 255));
    end
    wait_done();
  endtask

  // load held high: second conversion starts on the IDLE cycle that carries done.
  task automatic held_pair(int v1, int v2);
    int c0;
    @(posedge clk); #1;
    value = 8'(v1);
    load  = 1'b1;
    @(posedge clk); #1;
    c0    = cyc;
    value = 8'(v2);
    push(v1, c0);
    push(v2, c0 + 10);
    repeat (10) @(posedge clk);
    #1;
    load  = 1'b0;
    value = 8'($urandom_range(0, 255));
    wait_done();
  endtask

  task automatic reset_mid(int v);
    @(posedge clk); #1;
    value = 8'(v);
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    set_shown_reset();
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_ovf", 64'(ovf_a), 64'd0);
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_seg%0d", i), 64'(seg_a[i]), 64'(shown_seg[i]));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    set_shown_reset();
    check("init_busy", 64'(busy_a), 64'd0);
    check("init_done", 64'(done_a), 64'd0);
    check("init_ovf", 64'(ovf_a), 64'd0);
    check("init_seg0", 64'(seg0), 64'(21'b1111111_1111111_1000000));
    for (int i = 0; i < 3; i++)
      check($sformatf("init_seg%0d", i), 64'(seg_a[i]), 64'(shown_seg[i]));
    mon_en = 1'b1;

    convert(21, 1'b0);
    convert(255, 1'b0);
    convert(100, 1'b0);
    convert(0, 1'b0);
    convert(100, 1'b0);
    convert(7, 1'b0);
    convert(42, 1'b1);
    held_pair(123, 9);
    convert(100, 1'b0);
    reset_mid(77);
    convert(5, 1'b0);
    for (int n = 0; n < 40; n++) begin
      if (n % 10 == 9) held_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      else             convert(int'($urandom_range(0, 255)), n[0]);
    end

    repeat (15) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
